// File: rtl/secondary_input_receiver.sv
// Reassembles a 32-word, MS-word-first r/t stream into a pair of wide operands,
// capturing n0' at the start and publishing r/t atomically on the last word.
module secondary_input_receiver #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_LENGTH = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startTransfer,
  input  logic                   word_valid,
  input  logic [DATA_WIDTH-1:0]  r_word,
  input  logic [DATA_WIDTH-1:0]  t_word,
  input  logic [DATA_WIDTH-1:0]  n0p,
  output logic [DATA_LENGTH-1:0] r,
  output logic [DATA_LENGTH-1:0] t,
  output logic [DATA_WIDTH-1:0]  n0p_q,
  output logic                   busy,
  output logic                   done,
  output logic                   loaded,
  output logic [5:0]             word_count,
  output logic                   overflow
);
  localparam int WORDS = DATA_LENGTH / DATA_WIDTH;
  localparam logic [5:0] LAST = 6'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RECV, LOADED} state_t;
  state_t state;

  // Only WORDS-1 words ever need holding; the final word is merged on the fly.
  logic [DATA_LENGTH-DATA_WIDTH-1:0] r_sh, t_sh;
  logic [DATA_LENGTH-1:0]            r_nxt, t_nxt;

  assign r_nxt = {r_sh, r_word};
  assign t_nxt = {t_sh, t_word};
  assign busy  = (state == RECV);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      r_sh       <= '0;
      t_sh       <= '0;
      r          <= '0;
      t          <= '0;
      n0p_q      <= '0;
      done       <= 1'b0;
      loaded     <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (startTransfer) begin
        state      <= RECV;
        word_count <= '0;
        n0p_q      <= n0p;
        loaded     <= 1'b0;
        r_sh       <= '0;
        t_sh       <= '0;
      end else if (word_valid) begin
        if (state == RECV) begin
          r_sh       <= r_nxt[DATA_LENGTH-DATA_WIDTH-1:0];
          t_sh       <= t_nxt[DATA_LENGTH-DATA_WIDTH-1:0];
          word_count <= word_count + 6'd1;
          if (word_count == LAST) begin
            r      <= r_nxt;
            t      <= t_nxt;
            done   <= 1'b1;
            loaded <= 1'b1;
            state  <= LOADED;
          end
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end
endmodule
